// File: rtl/host_bus_interface_pkg.sv
// Shared definitions for the MCU host bus front end:
// opcode field, idle command, bus address map, status word layout.
package host_bus_interface_pkg;

  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 11;

  localparam logic [4:0] OP_NOP = 5'b11111;

  localparam logic [15:0] IDLE_CMD_DEF = {OP_NOP, 11'h000};

  localparam logic ADDR_CMD  = 1'b0;
  localparam logic ADDR_DATA = 1'b1;

  localparam int unsigned ST_OVF   = 15;
  localparam int unsigned ST_BUSY  = 14;
  localparam int unsigned ST_EMPTY = 13;

  typedef struct packed {
    logic [15:0] cmd;
    logic [15:0] data;
  } entry_t;

  function automatic logic [15:0] status_word(
    input logic       ovf,
    input logic       busy,
    input logic       empty,
    input logic [3:0] cnt
  );
    logic [15:0] w;
    w           = '0;
    w[ST_OVF]   = ovf;
    w[ST_BUSY]  = busy;
    w[ST_EMPTY] = empty;
    w[3:0]      = cnt;
    return w;
  endfunction

endpackage

// File: rtl/host_bus_interface_fifo.sv
// Synchronous FIFO for {command,data} entries. Ports: push/pop
// requests, wdata, head rdata, count, full, empty; async low reset.
module gpu_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A pop frees the slot the same cycle, so a full FIFO still
  // takes a coincident push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + (AW+1)'(1);
      else if (do_pop && !do_push)
        count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/host_bus_interface.sv
// MCU parallel bus front end: strobe sync, cmd/data pairing, FIFO.
// Ports: gpuClock/reset, bus pins, controller command/data/valid.
module host_bus_interface
  import host_bus_interface_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] IDLE_CMD    = IDLE_CMD_DEF
) (
  input  logic        gpuClock,
  input  logic        reset,
  input  logic        busCsN,
  input  logic        busWrN,
  input  logic        busRdN,
  input  logic        busAddr,
  input  logic [15:0] busDataIn,
  output logic [15:0] busDataOut,
  output logic        busDataOe,
  output logic        busBusy,
  input  logic [15:0] ctrlDataOut,
  input  logic        cmdAccept,
  output logic [15:0] command,
  output logic [15:0] data,
  output logic        cmdValid
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] wr_sync;
  logic [SYNC_STAGES-1:0] rd_sync;
  logic                   cs_n;
  logic                   wr_n;
  logic                   rd_n;
  logic                   wr_q;
  logic                   rd_q;

  logic                   wr_evt;
  logic                   rd_start;
  logic                   rd_end;
  logic                   rd_active;
  logic                   rd_addr;

  logic [15:0]            cmd_stage;
  logic                   overflow;

  logic                   push;
  logic                   pop;
  entry_t                 wentry;
  entry_t                 head;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [3:0]             cnt4;
  logic                   ovf_set;
  logic                   ovf_clr;

  always_ff @(posedge gpuClock or negedge reset) begin
    if (!reset) begin
      cs_sync <= '1;
      wr_sync <= '1;
      rd_sync <= '1;
      wr_q    <= 1'b1;
      rd_q    <= 1'b1;
    end else begin
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], busCsN};
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], busWrN};
      rd_sync <= {rd_sync[SYNC_STAGES-2:0], busRdN};
      wr_q    <= wr_n;
      rd_q    <= rd_n;
    end
  end

  assign cs_n = cs_sync[SYNC_STAGES-1];
  assign wr_n = wr_sync[SYNC_STAGES-1];
  assign rd_n = rd_sync[SYNC_STAGES-1];

  // Writes commit on the trailing (rising) strobe edge, reads
  // start on the leading edge; CS must be low at that edge.
  assign wr_evt   = wr_n & ~wr_q & ~cs_n;
  assign rd_start = ~rd_n & rd_q & ~cs_n;
  assign rd_end   = rd_n & ~rd_q & rd_active;

  assign push = wr_evt & (busAddr == ADDR_DATA);
  assign pop  = cmdAccept & cmdValid & ~fifo_empty;

  assign wentry.cmd  = cmd_stage;
  assign wentry.data = busDataIn;

  assign ovf_set = push & fifo_full & ~pop;
  assign ovf_clr = rd_end & (rd_addr == ADDR_CMD);

  assign cnt4 = 4'(fifo_count);

  gpu_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (gpuClock),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge gpuClock or negedge reset) begin
    if (!reset) begin
      cmd_stage <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr_evt && busAddr == ADDR_CMD) cmd_stage <= busDataIn;
      overflow <= ovf_set | (overflow & ~ovf_clr);
    end
  end

  always_ff @(posedge gpuClock or negedge reset) begin
    if (!reset) begin
      command  <= IDLE_CMD;
      data     <= '0;
      cmdValid <= 1'b0;
      busBusy  <= 1'b0;
    end else begin
      command  <= fifo_empty ? IDLE_CMD : head.cmd;
      data     <= fifo_empty ? 16'h0000 : head.data;
      cmdValid <= ~fifo_empty;
      busBusy  <= fifo_full;
    end
  end

  always_ff @(posedge gpuClock or negedge reset) begin
    if (!reset) begin
      busDataOut <= '0;
      busDataOe  <= 1'b0;
      rd_active  <= 1'b0;
      rd_addr    <= 1'b0;
    end else if (rd_start) begin
      busDataOe  <= 1'b1;
      rd_active  <= 1'b1;
      rd_addr    <= busAddr;
      busDataOut <= (busAddr == ADDR_DATA) ? ctrlDataOut :
                    status_word(overflow, busBusy, ~cmdValid, cnt4);
    end else if (rd_end) begin
      busDataOe  <= 1'b0;
      rd_active  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_host_bus_interface.sv
// Bench for host_bus_interface: directed cases plus random bus
// traffic checked against a queue model of the entry FIFO.
module tb_host_bus_interface;

  localparam int S     = 2;
  localparam int DEPTH = 8;
  localparam logic [15:0] IDLE = 16'hF800;

  logic        gpuClock = 1'b0;
  logic        reset;
  logic        busCsN;
  logic        busWrN;
  logic        busRdN;
  logic        busAddr;
  logic [15:0] busDataIn;
  logic [15:0] busDataOut;
  logic        busDataOe;
  logic        busBusy;
  logic [15:0] ctrlDataOut;
  logic        cmdAccept;
  logic [15:0] command;
  logic [15:0] data;
  logic        cmdValid;

  host_bus_interface #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (S),
    .IDLE_CMD    (IDLE)
  ) dut (
    .gpuClock    (gpuClock),
    .reset       (reset),
    .busCsN      (busCsN),
    .busWrN      (busWrN),
    .busRdN      (busRdN),
    .busAddr     (busAddr),
    .busDataIn   (busDataIn),
    .busDataOut  (busDataOut),
    .busDataOe   (busDataOe),
    .busBusy     (busBusy),
    .ctrlDataOut (ctrlDataOut),
    .cmdAccept   (cmdAccept),
    .command     (command),
    .data        (data),
    .cmdValid    (cmdValid)
  );

  always #5 gpuClock = ~gpuClock;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] q[$];
  logic [15:0] m_stage;
  logic        m_ovf;
  bit          settled = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] exp_status();
    logic [15:0] w;
    w        = '0;
    w[15]    = m_ovf;
    w[14]    = (q.size() == DEPTH);
    w[13]    = (q.size() == 0);
    w[3:0]   = 4'(q.size());
    return w;
  endfunction

  // Continuous comparison whenever the bus is quiet.
  always @(negedge gpuClock) begin
    if (settled) begin
      logic [31:0] hd;
      bit          ne;
      ne = (q.size() != 0);
      hd = ne ? q[0] : {IDLE, 16'h0000};
      check("cmdValid", {31'b0, cmdValid}, {31'b0, ne});
      check("command", {16'b0, command}, {16'b0, hd[31:16]});
      check("data", {16'b0, data}, {16'b0, hd[15:0]});
      check("busBusy", {31'b0, busBusy},
            {31'b0, q.size() == DEPTH});
    end
  end

  task automatic model_push(input logic [15:0] d, input bit acc);
    if (acc && q.size() > 0) void'(q.pop_front());
    if (q.size() < DEPTH) q.push_back({m_stage, d});
    else m_ovf = 1'b1;
  endtask

  task automatic host_write(input logic a, input logic [15:0] d,
                            input bit acc, output int lat);
    settled = 1'b0;
    lat = 0;
    @(posedge gpuClock); #1;
    busCsN = 1'b0; busAddr = a; busDataIn = d;
    @(posedge gpuClock); #1;
    busWrN = 1'b0;
    repeat (S + 2) @(posedge gpuClock);
    #1 busWrN = 1'b1;
    if (acc) begin
      repeat (S) @(posedge gpuClock);
      #1 cmdAccept = 1'b1;
      @(posedge gpuClock);
      #1 cmdAccept = 1'b0;
      repeat (4) @(posedge gpuClock);
    end else begin
      for (int k = 1; k <= S + 4; k++) begin
        @(posedge gpuClock); #1;
        if (cmdValid && lat == 0) lat = k;
      end
    end
    #1 busCsN = 1'b1;
    if (a == 1'b0) m_stage = d;
    else model_push(d, acc);
    settled = 1'b1;
  endtask

  task automatic wr(input logic a, input logic [15:0] d);
    int lat;
    host_write(a, d, 1'b0, lat);
  endtask

  task automatic host_read(input logic a, output logic [15:0] v,
                           output logic oe_seen);
    settled = 1'b0;
    @(posedge gpuClock); #1;
    check("oe_before", {31'b0, busDataOe}, 32'd0);
    busCsN = 1'b0; busAddr = a;
    @(posedge gpuClock); #1;
    busRdN = 1'b0;
    repeat (S + 3) @(posedge gpuClock);
    #1 oe_seen = busDataOe; v = busDataOut;
    busRdN = 1'b1;
    repeat (S + 3) @(posedge gpuClock);
    #1 check("oe_after", {31'b0, busDataOe}, 32'd0);
    busCsN = 1'b1;
    if (a == 1'b0) m_ovf = 1'b0;
    settled = 1'b1;
  endtask

  task automatic rd_status(input string name, input logic [15:0] lit);
    logic [15:0] v;
    logic        oe;
    logic [15:0] e;
    e = exp_status();
    host_read(1'b0, v, oe);
    check({name, "_oe"}, {31'b0, oe}, 32'd1);
    check({name, "_model"}, {16'b0, v}, {16'b0, e});
    check(name, {16'b0, v}, {16'b0, lit});
  endtask

  task automatic accept();
    settled = 1'b0;
    @(posedge gpuClock); #1 cmdAccept = 1'b1;
    @(posedge gpuClock); #1 cmdAccept = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    repeat (2) @(posedge gpuClock);
    #1 settled = 1'b1;
  endtask

  task automatic glitch_write(input logic [15:0] d);
    settled = 1'b0;
    @(posedge gpuClock); #1;
    busCsN = 1'b0; busAddr = 1'b1; busDataIn = d;
    @(posedge gpuClock); #1 busWrN = 1'b0;
    repeat (S + 2) @(posedge gpuClock);
    #1 busCsN = 1'b1;
    repeat (S + 2) @(posedge gpuClock);
    #1 busWrN = 1'b1;
    repeat (S + 4) @(posedge gpuClock);
    #1 settled = 1'b1;
  endtask

  task automatic pulse_reset();
    settled = 1'b0;
    @(posedge gpuClock); #1 reset = 1'b0;
    #1;
    check("rst_cmdValid", {31'b0, cmdValid}, 32'd0);
    check("rst_command", {16'b0, command}, 32'h0000F800);
    check("rst_data", {16'b0, data}, 32'd0);
    check("rst_busBusy", {31'b0, busBusy}, 32'd0);
    check("rst_oe", {31'b0, busDataOe}, 32'd0);
    check("rst_dout", {16'b0, busDataOut}, 32'd0);
    repeat (2) @(posedge gpuClock);
    #1 reset = 1'b1;
    q.delete(); m_stage = '0; m_ovf = 1'b0;
    @(posedge gpuClock); #1 settled = 1'b1;
  endtask

  initial begin
    logic [15:0] v;
    logic        oe;
    int          lat;
    reset = 1'b1; busCsN = 1'b1; busWrN = 1'b1; busRdN = 1'b1;
    busAddr = 1'b0; busDataIn = '0; ctrlDataOut = '0;
    cmdAccept = 1'b0; m_stage = '0; m_ovf = 1'b0;

    pulse_reset();

    // Reset mid-stream.
    wr(1'b0, 16'h1111);
    for (int i = 0; i < 3; i++) wr(1'b1, 16'(i + 1));
    check("pre_rst_valid", {31'b0, cmdValid}, 32'd1);
    pulse_reset();
    rd_status("rst_status", 16'h2000);

    // Single entry, latency, accept.
    wr(1'b0, 16'h9001);
    host_write(1'b1, 16'h00AA, 1'b0, lat);
    check("latency", lat, S + 2);
    check("t2_command", {16'b0, command}, 32'h00009001);
    check("t2_data", {16'b0, data}, 32'h000000AA);
    accept();
    check("t2_idle_valid", {31'b0, cmdValid}, 32'd0);
    check("t2_idle_cmd", {16'b0, command}, 32'h0000F800);

    // Fill to full and overflow.
    wr(1'b0, 16'h8805);
    for (int i = 1; i <= 9; i++) begin
      wr(1'b1, 16'(i));
      if (i == 7) check("busy_at7", {31'b0, busBusy}, 32'd0);
      if (i == 8) check("busy_at8", {31'b0, busBusy}, 32'd1);
    end
    rd_status("status_ovf", 16'hC008);
    rd_status("status_clr", 16'h4008);

    // Coincident pop and push while full.
    pulse_reset();
    wr(1'b0, 16'h8805);
    for (int i = 1; i <= 8; i++) wr(1'b1, 16'(i));
    host_write(1'b1, 16'd9, 1'b1, lat);
    rd_status("status_coinc", 16'h4008);
    for (int i = 2; i <= 9; i++) begin
      check("drain_data", {16'b0, data}, 32'(i));
      check("drain_cmd", {16'b0, command}, 32'h00008805);
      accept();
    end
    check("drained", {31'b0, cmdValid}, 32'd0);

    // Data register read-back.
    ctrlDataOut = 16'h1234;
    host_read(1'b1, v, oe);
    check("rd1_oe", {31'b0, oe}, 32'd1);
    check("rd1_data", {16'b0, v}, 32'h00001234);

    // Random traffic with glitches and gaps.
    for (int n = 0; n < 120; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) wr(1'b0, 16'($urandom));
      else if (r <= 4) wr(1'b1, 16'($urandom));
      else if (r <= 6) accept();
      else if (r == 7) glitch_write(16'($urandom));
      else if (r == 8) begin
        logic [15:0] e;
        e = exp_status();
        host_read(1'b0, v, oe);
        check("rnd_status", {16'b0, v}, {16'b0, e});
      end else begin
        logic [15:0] c;
        c = 16'($urandom);
        ctrlDataOut = c;
        host_read(1'b1, v, oe);
        check("rnd_rd1", {16'b0, v}, {16'b0, c});
      end
      repeat ($urandom_range(0, 3)) @(posedge gpuClock);
    end
    for (int k = 0; k < DEPTH + 1; k++) accept();
    check("final_empty", {31'b0, cmdValid}, 32'd0);

    settled = 1'b0;
    repeat (2) @(posedge gpuClock);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
